// File: rtl/pkt_grant_mux_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_grant_mux_if : requester, arbiter and output bundle of pkt_grant_mux
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pkt_grant_mux_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          in_valid_i;
  logic [4*DATA_W-1:0] in_data_i;
  logic [3:0]          in_last_i;
  logic [3:0]          in_ready_o;
  logic [3:0]          arb_req_o;
  logic [3:0]          arb_gnt_i;
  logic                out_valid_o;
  logic [DATA_W-1:0]   out_data_o;
  logic                out_last_o;
  logic [1:0]          out_port_o;
  logic                out_ready_i;
  logic                busy_o;
  logic                gnt_err_o;

  // Mux side
  modport slave (
    input  in_valid_i, in_data_i, in_last_i, arb_gnt_i, out_ready_i,
    output in_ready_o, arb_req_o, out_valid_o, out_data_o, out_last_o,
           out_port_o, busy_o, gnt_err_o
  );

  // Requesters / arbiter / downstream side
  modport master (
    output in_valid_i, in_data_i, in_last_i, arb_gnt_i, out_ready_i,
    input  in_ready_o, arb_req_o, out_valid_o, out_data_o, out_last_o,
           out_port_o, busy_o, gnt_err_o
  );
endinterface
`default_nettype wire

// File: rtl/pkt_grant_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_grant_mux : 4-port packet mux, locks onto an arbiter grant until last
// Revision: 1.0
// ---------------------------------------------------------------------------
module pkt_grant_mux #(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  pkt_grant_mux_if.slave  bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [1:0]        lock_port;
  logic [1:0]        gnt_idx;
  logic              gnt_onehot;
  logic              gnt_legal;
  logic              slot_free;
  logic              accept;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  logic [3:0]        arb_req;
  logic [3:0]        in_ready;
  logic              busy;
  logic              gnt_err;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        out_port;

  // A grant is only honoured when exactly one bit is set and that port is valid
  assign gnt_onehot = (bus.arb_gnt_i != 4'b0000) &&
                      ((bus.arb_gnt_i & (bus.arb_gnt_i - 4'd1)) == 4'b0000);
  assign gnt_legal  = gnt_onehot && ((bus.arb_gnt_i & bus.in_valid_i) != 4'b0000);

  always_comb begin
    gnt_idx = 2'd0;
    case (bus.arb_gnt_i)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  assign slot_free = !out_valid || bus.out_ready_i;
  assign sel_data  = bus.in_data_i[lock_port*DATA_W +: DATA_W];
  assign sel_last  = bus.in_last_i[lock_port];
  assign accept    = (state == ST_LOCKED) && bus.in_valid_i[lock_port] && slot_free;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      lock_port <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && gnt_legal) begin
        lock_port <= gnt_idx;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_legal) begin
          state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept && sel_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; requests are withheld while locked so the arbiter only
  // advances on real grant decisions.
  always_comb begin
    arb_req  = 4'b0000;
    in_ready = 4'b0000;
    busy     = 1'b0;
    gnt_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        arb_req = bus.in_valid_i;
        gnt_err = (bus.arb_gnt_i != 4'b0000) && !gnt_legal && !reset;
      end
      ST_LOCKED: begin
        busy                = 1'b1;
        in_ready[lock_port] = slot_free;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Output beat register: payload only changes when a new beat is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_port  <= 2'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_port  <= lock_port;
    end else if (bus.out_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.arb_req_o   = arb_req;
  assign bus.in_ready_o  = in_ready;
  assign bus.busy_o      = busy;
  assign bus.gnt_err_o   = gnt_err;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.out_last_o  = out_last;
  assign bus.out_port_o  = out_port;

endmodule
`default_nettype wire

// File: tb/tb_pkt_grant_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pkt_grant_mux : directed vectors plus arbiter-in-loop sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pkt_grant_mux;

  localparam int DATA_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pkt_grant_mux_if #(.DATA_W(DATA_W)) bus ();

  pkt_grant_mux #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bench-side round-robin arbiter: searches downward from ptr
  logic       arb_mode = 1'b0;
  logic [3:0] gnt_drv  = 4'b0000;
  logic [1:0] ptr      = 2'd3;
  logic [3:0] rr_gnt;

  function automatic logic [3:0] rr(input logic [3:0] req, input logic [1:0] p);
    logic [3:0] g;
    logic [1:0] idx;
    g = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = p - k[1:0];
      if (g == 4'b0000 && req[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  always_comb begin
    rr_gnt        = rr(bus.arb_req_o, ptr);
    bus.arb_gnt_i = arb_mode ? rr_gnt : gnt_drv;
  end

  always @(posedge clk) begin
    if (arb_mode && rr_gnt != 4'b0000) begin
      case (rr_gnt)
        4'b0001: ptr <= 2'd3;
        4'b0010: ptr <= 2'd0;
        4'b0100: ptr <= 2'd1;
        default: ptr <= 2'd2;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic [3:0]  g;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic [3:0]  e_req;
    logic        e_busy;
    logic        e_err;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic [1:0]  e_op;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                              input logic [3:0] g, input logic ordy, input logic [3:0] e_rdy,
                              input logic [3:0] e_req, input logic e_busy, input logic e_err,
                              input logic e_ov, input logic [7:0] e_od, input logic e_ol,
                              input logic [1:0] e_op);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.g = g; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_req = e_req; r.e_busy = e_busy; r.e_err = e_err;
    r.e_ov = e_ov; r.e_od = e_od; r.e_ol = e_ol; r.e_op = e_op;
    return r;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                       input logic ordy);
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.in_last_i   = l;
    bus.out_ready_i = ordy;
  endtask

  vec_t tbl [15];

  initial begin
    logic [3:0]  vmask;
    logic [7:0]  rx_data [$];
    logic        rx_last [$];
    logic [1:0]  rx_port [$];
    logic [1:0]  exp_port;
    int          bi;
    int          cyc;
    logic        got;

    // Port 0: A1..A3; illegal grants; port 2 locked while port 3 asks; port 3 single beat
    tbl[0]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0, 2'd0);
    tbl[1]  = mk(4'b0001, 32'h0000_00A1, 4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0001, 0, 0, 0, 8'h00, 0, 2'd0);
    tbl[2]  = mk(4'b0001, 32'h0000_00A1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1, 0, 0, 8'h00, 0, 2'd0);
    tbl[3]  = mk(4'b0001, 32'h0000_00A2, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1, 0, 1, 8'hA1, 0, 2'd0);
    tbl[4]  = mk(4'b0001, 32'h0000_00A3, 4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1, 0, 1, 8'hA2, 0, 2'd0);
    tbl[5]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 1, 8'hA3, 1, 2'd0);
    tbl[6]  = mk(4'b0110, 32'h0000_5500, 4'b0110, 4'b0110, 1'b1, 4'b0000, 4'b0110, 0, 1, 0, 8'hA3, 1, 2'd0);
    tbl[7]  = mk(4'b0110, 32'h0000_5500, 4'b0110, 4'b1000, 1'b1, 4'b0000, 4'b0110, 0, 1, 0, 8'hA3, 1, 2'd0);
    tbl[8]  = mk(4'b0100, 32'h00C1_0000, 4'b0000, 4'b0100, 1'b1, 4'b0000, 4'b0100, 0, 0, 0, 8'hA3, 1, 2'd0);
    tbl[9]  = mk(4'b1100, 32'h33C1_0000, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1, 0, 0, 8'hA3, 1, 2'd0);
    tbl[10] = mk(4'b1100, 32'h33C2_0000, 4'b1100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1, 0, 1, 8'hC1, 0, 2'd2);
    tbl[11] = mk(4'b1000, 32'hD100_0000, 4'b1000, 4'b1000, 1'b1, 4'b0000, 4'b1000, 0, 0, 1, 8'hC2, 1, 2'd2);
    tbl[12] = mk(4'b1000, 32'hD100_0000, 4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 1, 0, 0, 8'hC2, 1, 2'd2);
    tbl[13] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 1, 8'hD1, 1, 2'd3);
    tbl[14] = mk(4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 8'hD1, 1, 2'd3);

    // Reset state, with an illegal grant present that must not flag
    drive(4'b0100, 32'h0000_0000, 4'b0000, 1'b1);
    gnt_drv = 4'b0110;
    #12;
    chk("rst_ov",   32'(bus.out_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o),      32'd0);
    chk("rst_err",  32'(bus.gnt_err_o),   32'd0);
    chk("rst_od",   32'(bus.out_data_o),  32'd0);
    chk("rst_op",   32'(bus.out_port_o),  32'd0);
    chk("rst_ol",   32'(bus.out_last_o),  32'd0);
    chk("rst_rdy",  32'(bus.in_ready_o),  32'd0);
    gnt_drv = 4'b0000;
    drive(4'b0000, 32'h0, 4'b0000, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
      gnt_drv = tbl[i].g;
      @(negedge clk);
      chk($sformatf("v%0d_rdy",  i), 32'(bus.in_ready_o),  32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_req",  i), 32'(bus.arb_req_o),   32'(tbl[i].e_req));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy_o),      32'(tbl[i].e_busy));
      chk($sformatf("v%0d_err",  i), 32'(bus.gnt_err_o),   32'(tbl[i].e_err));
      chk($sformatf("v%0d_ov",   i), 32'(bus.out_valid_o), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_od",   i), 32'(bus.out_data_o),  32'(tbl[i].e_od));
      chk($sformatf("v%0d_ol",   i), 32'(bus.out_last_o),  32'(tbl[i].e_ol));
      chk($sformatf("v%0d_op",   i), 32'(bus.out_port_o),  32'(tbl[i].e_op));
    end

    // All four ports with single-beat packets, arbiter in the loop: 3,2,1,0
    gnt_drv  = 4'b0000;
    arb_mode = 1'b1;
    vmask    = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      drive(vmask, 32'h1312_1110, 4'b1111, 1'b1);
      @(negedge clk);
      chk($sformatf("rr%0d_ov", c), 32'(bus.out_valid_o),
          32'((c == 2) || (c == 4) || (c == 6) || (c == 8)));
      chk($sformatf("rr%0d_busy", c), 32'(bus.busy_o), 32'((c % 2 == 1) && (c < 8)));
      if (bus.out_valid_o && c >= 2 && c <= 8) begin
        exp_port = 2'(3 - (c - 2) / 2);
        chk($sformatf("rr%0d_op", c), 32'(bus.out_port_o), 32'(exp_port));
        chk($sformatf("rr%0d_od", c), 32'(bus.out_data_o), 32'(8'h10 + 8'(exp_port)));
      end
      vmask = vmask & ~(bus.in_ready_o & bus.in_valid_i);
    end

    // Port 1, 4 beats, downstream stalls for 4 cycles mid-packet
    bi  = 0;
    cyc = 0;
    while (rx_data.size() < 4 && cyc < 40) begin
      @(posedge clk); #1;
      drive((bi < 4) ? 4'b0010 : 4'b0000, 32'(8'hB1 + 8'(bi)) << 8,
            (bi == 3) ? 4'b0010 : 4'b0000, !(cyc >= 3 && cyc <= 6));
      @(negedge clk);
      if (!bus.out_ready_i) begin
        chk($sformatf("stall%0d_rdy", cyc), 32'(bus.in_ready_o[1]), 32'd0);
        chk($sformatf("stall%0d_od",  cyc), 32'(bus.out_data_o),   32'hB2);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        rx_data.push_back(bus.out_data_o);
        rx_last.push_back(bus.out_last_o);
        rx_port.push_back(bus.out_port_o);
      end
      if (bus.in_ready_o[1] && bus.in_valid_i[1]) bi++;
      cyc++;
    end
    chk("stall_count", 32'(rx_data.size()), 32'd4);
    chk("stall_cycles", 32'(cyc), 32'd10);
    for (int k = 0; k < 4 && k < rx_data.size(); k++) begin
      chk($sformatf("stall_rx%0d_d", k), 32'(rx_data[k]), 32'(8'hB1 + 8'(k)));
      chk($sformatf("stall_rx%0d_l", k), 32'(rx_last[k]), 32'(k == 3));
      chk($sformatf("stall_rx%0d_p", k), 32'(rx_port[k]), 32'd1);
    end

    // Port 0, 5-beat packet, reset lands with beat 2 on the output
    bi = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive(4'b0001, 32'(8'hE1 + 8'(bi)), (bi == 4) ? 4'b0001 : 4'b0000, 1'b1);
      @(negedge clk);
      if (c < 3 && bus.in_ready_o[0] && bus.in_valid_i[0]) bi++;
    end
    chk("mid_ov",   32'(bus.out_valid_o), 32'd1);
    chk("mid_od",   32'(bus.out_data_o),  32'hE2);
    chk("mid_busy", 32'(bus.busy_o),      32'd1);
    reset = 1'b1;
    #1;
    chk("arst_ov",   32'(bus.out_valid_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o),      32'd0);
    chk("arst_od",   32'(bus.out_data_o),  32'd0);
    chk("arst_op",   32'(bus.out_port_o),  32'd0);
    drive(4'b0000, 32'h0, 4'b0000, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(posedge clk); #1;
      drive(4'b0100, 32'h00F1_0000, 4'b0100, 1'b1);
      @(negedge clk);
      if (bus.out_valid_o) got = 1'b1;
      else cyc++;
    end
    chk("restart_got", 32'(got),             32'd1);
    chk("restart_lat", 32'(cyc),             32'd2);
    chk("restart_od",  32'(bus.out_data_o),  32'hF1);
    chk("restart_op",  32'(bus.out_port_o),  32'd2);
    chk("restart_ol",  32'(bus.out_last_o),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pkt_grant_mux.md
PKT_GRANT_MUX -- requirements
Module: pkt_grant_mux

Interface
REQ-001 Parameter: DATA_W, default 8, payload width per channel.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid_i  input  4  per-requester beat valid; bit n = requester n.
REQ-005 in_data_i  input  4*DATA_W  per-requester payload; requester n occupies bits [n*DATA_W +: DATA_W].
REQ-006 in_last_i  input  4  per-requester end-of-packet flag, qualified by in_valid_i.
REQ-007 in_ready_o  output  4  per-requester beat accept.
REQ-008 arb_req_o  output  4  request vector driven to the external 4-port round-robin arbiter.
REQ-009 arb_gnt_i  input  4  combinational one-hot grant returned by the arbiter.
REQ-010 out_valid_o  output  1  output beat valid (registered).
REQ-011 out_data_o  output  DATA_W  output payload (registered).
REQ-012 out_last_o  output  1  output end-of-packet (registered).
REQ-013 out_port_o  output  2  index of the requester that sourced the output beat (registered).
REQ-014 out_ready_i  input  1  downstream accept.
REQ-015 busy_o  output  1  high while in LOCKED.
REQ-016 gnt_err_o  output  1  one-cycle pulse on an illegal grant.

Function
REQ-017 The FSM SHALL have two states: IDLE (arbitrate) and LOCKED (forward the packet of the locked port).
REQ-018 In IDLE, arb_req_o SHALL equal in_valid_i; in LOCKED, arb_req_o SHALL be 4'b0000, so the arbiter's pointer advances only on real grant decisions.
REQ-019 In IDLE, a one-hot arb_gnt_i whose bit is also set in in_valid_i SHALL register that port index as lock_port and move to LOCKED at the next edge.
REQ-020 In IDLE, in_ready_o SHALL be 4'b0000; no beat is accepted in the arbitration cycle.
REQ-021 In IDLE, arb_gnt_i == 0 SHALL leave the FSM in IDLE.
REQ-022 In IDLE, an arb_gnt_i with more than one bit set, or with its bit set for a port whose valid is low, SHALL be ignored (stay IDLE), and gnt_err_o SHALL pulse high for that cycle.
REQ-023 slot_free SHALL equal (!out_valid_o || out_ready_i).
REQ-024 In LOCKED, in_ready_o[lock_port] SHALL equal slot_free, and all other in_ready_o bits SHALL be 0.
REQ-025 A beat is accepted when in_valid_i[lock_port] && in_ready_o[lock_port]; on the next edge the output register SHALL load data, last and lock_port, and out_valid_o SHALL be set to 1.
REQ-026 If out_ready_i is high and no beat is accepted, out_valid_o SHALL clear at the next edge.
REQ-027 While out_valid_o && !out_ready_i, out_data_o, out_last_o and out_port_o SHALL be held stable.
REQ-028 An accepted beat with in_last_i[lock_port] = 1 SHALL return the FSM to IDLE at the next edge.
REQ-029 Sustained throughput in LOCKED SHALL be one beat per cycle when out_ready_i is held high.
REQ-030 Minimum inter-packet overhead SHALL be one IDLE cycle.
REQ-031 Latency from acceptance to out_valid_o SHALL be 1 cycle.
REQ-032 A single-beat packet (valid and last in the same beat) SHALL occupy exactly one LOCKED cycle when the slot is free.
REQ-033 Changes on non-locked ports during LOCKED SHALL have no effect.
REQ-034 The locked packet SHALL never be preempted.
REQ-035 In LOCKED with in_valid_i[lock_port] low, the FSM SHALL wait indefinitely (no timeout).

Reset
REQ-036 While reset is high, the FSM SHALL be in IDLE and lock_port SHALL be 0.
REQ-037 While reset is high, out_valid_o, out_last_o, busy_o and gnt_err_o SHALL be 0, and out_data_o and out_port_o SHALL be 0.
REQ-038 Assertion of reset in the middle of a packet SHALL discard the partial packet and any pending output beat immediately; after release the block SHALL re-arbitrate from IDLE.

Verification
REQ-039 Scenario: in_valid_i=0001, 3-beat packet 0xA1,0xA2,0xA3 (last on the third beat), gnt=0001, out_ready_i=1 -> busy_o high for 3 cycles; out beats A1,A2,A3 on consecutive cycles with out_port_o=0 and out_last_o on A3.
REQ-040 Scenario: all four ports valid with 1-beat packets, arbiter in the loop -> out_port_o sequence 3,2,1,0 with one IDLE cycle between packets.
REQ-041 Scenario: out_ready_i low for 4 cycles mid-packet -> out_data_o stable, in_ready_o[lock_port]=0 during the stall, and no beat lost or duplicated.
REQ-042 Scenario: force arb_gnt_i=0110 in IDLE -> gnt_err_o pulses for 1 cycle, the FSM stays IDLE and no beat is accepted.
REQ-043 Scenario: port 2 locked, port 3 raises valid mid-packet -> in_ready_o[3] stays 0 and arb_req_o stays 0000 until after port 2's last beat.
REQ-044 Scenario: assert reset after beat 2 of a 5-beat packet -> out_valid_o and busy_o go to 0 immediately; after release a fresh grant restarts cleanly.
